// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared op encoding and segment-count helper for the pipelined CLA adder
package cla_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_ADC = 2'd2;
  localparam logic [1:0] OP_SBB = 2'd3;

  function automatic int seg_count(input int width, input int seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/cla_seg.sv
// rtl/cla_seg.sv - one SEG_W-bit single-level generate/propagate lookahead segment
module cla_seg #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [SEG_W-1:0] g;
  logic [SEG_W-1:0] p;
  logic [SEG_W:0]   c;
  logic             term;

  // Each carry is a flat sum of products of g/p/cin, so depth does not grow with bit position.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    term = 1'b0;
    for (int i = 0; i <= SEG_W; i++) begin
      term = cin;
      for (int m = 0; m < i; m++) term = term & p[m];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    s     = p ^ c[SEG_W-1:0];
    cout  = c[SEG_W];
    c_msb = c[SEG_W-1];
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead add/sub, one segment per stage, valid/ready handshake
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n
);

  localparam int NSEG = seg_count(WIDTH, SEG_W);
  localparam int LAST = NSEG - 1;

  logic             adv;
  logic             cin_eff;
  logic [WIDTH-1:0] b_eff;

  // Stage registers; operands shift right as segments are consumed, sum shifts in from the top.
  logic             vld_q [NSEG];
  logic [1:0]       op_q  [NSEG];
  logic [WIDTH-1:0] sum_q [NSEG];
  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic             c_q   [NSEG];
  logic             z_q   [NSEG];

  logic             st_vld [NSEG];
  logic [1:0]       st_op  [NSEG];
  logic [WIDTH-1:0] st_sum [NSEG];
  logic [WIDTH-1:0] st_a   [NSEG];
  logic [WIDTH-1:0] st_b   [NSEG];
  logic             st_cin [NSEG];
  logic             st_z   [NSEG];

  logic [SEG_W-1:0] seg_s  [NSEG];
  logic             seg_co [NSEG];
  logic             seg_cm [NSEG];

  logic fin_c;
  logic fin_v;
  logic fin_z;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && !flush;
  assign out_valid = vld_q[LAST];
  assign out_sum   = sum_q[LAST];

  always_comb begin
    b_eff = in_op[0] ? ~in_b : in_b;
    case (in_op)
      OP_ADD:  cin_eff = 1'b0;
      OP_SUB:  cin_eff = 1'b1;
      OP_ADC:  cin_eff = in_cin;
      default: cin_eff = ~in_cin;
    endcase
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign st_vld[k] = in_valid && in_ready;
      assign st_op[k]  = in_op;
      assign st_sum[k] = '0;
      assign st_a[k]   = in_a;
      assign st_b[k]   = b_eff;
      assign st_cin[k] = cin_eff;
      assign st_z[k]   = 1'b1;
    end else begin : g_next
      assign st_vld[k] = vld_q[k-1];
      assign st_op[k]  = op_q[k-1];
      assign st_sum[k] = sum_q[k-1];
      assign st_a[k]   = a_q[k-1];
      assign st_b[k]   = b_q[k-1];
      assign st_cin[k] = c_q[k-1];
      assign st_z[k]   = z_q[k-1];
    end

    cla_seg #(.SEG_W(SEG_W)) u_seg (
      .a     (st_a[k][SEG_W-1:0]),
      .b     (st_b[k][SEG_W-1:0]),
      .cin   (st_cin[k]),
      .s     (seg_s[k]),
      .cout  (seg_co[k]),
      .c_msb (seg_cm[k])
    );
  end

  // Signed overflow as carry-into-MSB xor carry-out: same truth table as the operand/result sign test.
  assign fin_c = st_op[LAST][0] ? ~seg_co[LAST] : seg_co[LAST];
  assign fin_v = seg_co[LAST] ^ seg_cm[LAST];
  assign fin_z = st_z[LAST] && (seg_s[LAST] == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        vld_q[k] <= 1'b0;
        sum_q[k] <= '0;
      end
      out_c <= 1'b0;
      out_v <= 1'b0;
      out_z <= 1'b0;
      out_n <= 1'b0;
    end else begin
      if (flush) begin
        for (int k = 0; k < NSEG; k++) vld_q[k] <= 1'b0;
      end else if (adv) begin
        for (int k = 0; k < NSEG; k++) vld_q[k] <= st_vld[k];
      end
      if (adv) begin
        for (int k = 0; k < NSEG; k++) begin
          op_q[k]  <= st_op[k];
          sum_q[k] <= (st_sum[k] >> SEG_W) | (WIDTH'(seg_s[k]) << (WIDTH - SEG_W));
          a_q[k]   <= st_a[k] >> SEG_W;
          b_q[k]   <= st_b[k] >> SEG_W;
          c_q[k]   <= seg_co[k];
          z_q[k]   <= st_z[k] && (seg_s[k] == '0);
        end
        out_c <= fin_c;
        out_v <= fin_v;
        out_z <= fin_z;
        out_n <= seg_s[LAST][SEG_W-1];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - directed vector table, handshake/flush/reset sequences and a 32-bit model sweep
module tb_cla_pipe_adder;
  import cla_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic [3:0]  cvzn;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // 16-bit, 4 stages
  logic        flush = 1'b0, in_valid = 1'b0, in_ready, in_cin = 1'b0;
  logic [1:0]  in_op = 2'd0;
  logic [15:0] in_a = '0, in_b = '0, out_sum;
  logic        out_valid, out_ready = 1'b1, out_c, out_v, out_z, out_n;

  // 8-bit, single stage
  logic        h_flush = 1'b0, h_in_valid = 1'b0, h_in_ready, h_in_cin = 1'b0;
  logic [1:0]  h_in_op = 2'd0;
  logic [7:0]  h_in_a = '0, h_in_b = '0, h_out_sum;
  logic        h_out_valid, h_out_ready = 1'b1, h_out_c, h_out_v, h_out_z, h_out_n;

  // 32-bit, 4 stages of 8
  logic        w_flush = 1'b0, w_in_valid = 1'b0, w_in_ready, w_in_cin = 1'b0;
  logic [1:0]  w_in_op = 2'd0;
  logic [31:0] w_in_a = '0, w_in_b = '0, w_out_sum;
  logic        w_out_valid, w_out_ready = 1'b1, w_out_c, w_out_v, w_out_z, w_out_n;

  cla_pipe_adder #(.WIDTH(16), .SEG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n)
  );

  cla_pipe_adder #(.WIDTH(8), .SEG_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(h_flush), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_op(h_in_op), .in_a(h_in_a), .in_b(h_in_b), .in_cin(h_in_cin), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .out_sum(h_out_sum), .out_c(h_out_c), .out_v(h_out_v), .out_z(h_out_z), .out_n(h_out_n)
  );

  cla_pipe_adder #(.WIDTH(32), .SEG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_op(w_in_op), .in_a(w_in_a), .in_b(w_in_b), .in_cin(w_in_cin), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_sum(w_out_sum), .out_c(w_out_c), .out_v(w_out_v), .out_z(w_out_z), .out_n(w_out_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [35:0] model(input int w, input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    logic [63:0] mask, full;
    logic [31:0] bb, s;
    logic ci, co, c, v;
    mask = (64'd1 << w) - 64'd1;
    bb = (op[0] ? ~b : b) & mask[31:0];
    case (op)
      2'd0:    ci = 1'b0;
      2'd1:    ci = 1'b1;
      2'd2:    ci = cin;
      default: ci = ~cin;
    endcase
    full = {32'b0, a} + {32'b0, bb} + {63'b0, ci};
    s  = full[31:0] & mask[31:0];
    co = full[w];
    c  = op[0] ? ~co : co;
    v  = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {c, v, (s == 32'd0), s[w-1], s};
  endfunction

  // 16-bit output monitor: collects accepted results and checks that stalled outputs hold.
  logic [15:0] rx[$];
  logic        mon_en = 1'b0, stab_en = 1'b0, hold_prev = 1'b0;
  logic [15:0] hold_sum = '0;
  always @(negedge clk) begin
    #3;
    if (mon_en && out_valid && out_ready) rx.push_back(out_sum);
    if (stab_en && hold_prev) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(out_sum), 32'(hold_sum));
    end
    hold_prev = out_valid && !out_ready;
    hold_sum  = out_sum;
  end

  logic [35:0] exp32[$];
  always @(negedge clk) begin
    logic [35:0] e;
    #3;
    if (rst_n && w_out_valid) begin
      if (exp32.size() == 0) chk("w_extra", 32'd1, 32'd0);
      else begin
        e = exp32.pop_front();
        chk("w_sum", w_out_sum, e[31:0]);
        chk("w_flags", 32'({w_out_c, w_out_v, w_out_z, w_out_n}), 32'(e[35:32]));
      end
    end
  end

  task automatic run16(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    in_op = v.op; in_a = v.a; in_b = v.b; in_cin = v.cin; in_valid = 1'b1;
    #1 chk($sformatf("%s_ready", tag), 32'(in_ready), 32'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    #1;
    chk($sformatf("%s_latency", tag), 32'(lat), 32'd4);
    chk($sformatf("%s_sum", tag), 32'(out_sum), 32'(v.sum));
    chk($sformatf("%s_cvzn", tag), 32'({out_c, out_v, out_z, out_n}), 32'(v.cvzn));
  endtask

  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] sum, input logic [3:0] cvzn, input string tag);
    int lat;
    @(negedge clk);
    h_in_op = op; h_in_a = a; h_in_b = b; h_in_valid = 1'b1;
    #1 chk($sformatf("%s_ready", tag), 32'(h_in_ready), 32'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    h_in_valid = 1'b0;
    while (!h_out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    #1;
    chk($sformatf("%s_latency", tag), 32'(lat), 32'd1);
    chk($sformatf("%s_sum", tag), 32'(h_out_sum), 32'(sum));
    chk($sformatf("%s_cvzn", tag), 32'({h_out_c, h_out_v, h_out_z, h_out_n}), 32'(cvzn));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    int tries;
    vecs[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101};
    vecs[1]  = '{OP_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b1001};
    vecs[2]  = '{OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0100};
    vecs[3]  = '{OP_ADC, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b1010};
    vecs[4]  = '{OP_SBB, 16'h0005, 16'h0003, 1'b1, 16'h0001, 4'b0000};
    vecs[5]  = '{OP_ADD, 16'h1234, 16'h4321, 1'b1, 16'h5555, 4'b0000};
    vecs[6]  = '{OP_SUB, 16'h1234, 16'h1234, 1'b0, 16'h0000, 4'b0010};
    vecs[7]  = '{OP_ADC, 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 4'b0000};
    vecs[8]  = '{OP_SBB, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 4'b1001};
    vecs[9]  = '{OP_ADD, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 4'b1001};
    vecs[10] = '{OP_ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 4'b1110};
    vecs[11] = '{OP_SUB, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 4'b1101};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_flags", 32'({out_c, out_v, out_z, out_n}), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid8", 32'(h_out_valid), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run16(vecs[i], $sformatf("v%0d", i));

    run8(OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1010, "h_add");
    run8(OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b1001, "h_sub");
    run8(OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0101, "h_ovf");

    // Stream of six ADDs with a three-cycle output stall in the middle.
    @(negedge clk);
    rx.delete();
    mon_en = 1'b1;
    stab_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          in_valid = 1'b1; in_op = OP_ADD; in_a = 16'(i); in_b = 16'h1000; in_cin = 1'b0;
          #1;
          tries = 0;
          while (!in_ready && tries < 20) begin
            @(negedge clk);
            #1;
            tries++;
          end
          @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          #1;
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    tries = 0;
    while (rx.size() < 6 && tries < 30) begin
      @(negedge clk);
      tries++;
    end
    repeat (4) @(negedge clk);
    #4;
    chk("stream_count", 32'(rx.size()), 32'd6);
    for (int i = 0; i < 6 && i < rx.size(); i++)
      chk($sformatf("stream_%0d", i), 32'(rx[i]), 32'h1000 + 32'(i));
    stab_en = 1'b0;

    // Flush with three ops in flight and a fourth offered alongside it.
    rx.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = OP_ADD; in_a = 16'(16'h0111 * (k + 1)); in_b = 16'h0000;
    end
    @(negedge clk);
    in_a = 16'h0F00;
    flush = 1'b1;
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    in_a = 16'h0042; in_b = 16'h0001;
    #1 chk("post_flush_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #4;
    chk("flush_count", 32'(rx.size()), 32'd1);
    if (rx.size() > 0) chk("flush_next_sum", 32'(rx[0]), 32'h0043);

    // Reset while the output is stalled with ops still in flight.
    rx.delete();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_SUB; in_a = 16'h0000; in_b = 16'h0001;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_sum", 32'(out_sum), 32'h0000FFFF);
    chk("pre_rst_flags", 32'({out_c, out_v, out_z, out_n}), 32'b1001);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(out_sum), 32'd0);
    chk("mid_rst_flags", 32'({out_c, out_v, out_z, out_n}), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    #4;
    chk("rst_no_output", 32'(rx.size()), 32'd0);
    mon_en = 1'b0;
    run16(vecs[11], "post_rst");

    // 32-bit sweep against the reference model, one op per cycle.
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      w_in_op  = 2'($urandom_range(0, 3));
      w_in_a   = $urandom;
      w_in_b   = $urandom;
      w_in_cin = 1'($urandom_range(0, 1));
      if (i == 0) begin w_in_op = OP_ADC; w_in_a = 32'hFFFF_FFFF; w_in_b = 32'h0; w_in_cin = 1'b1; end
      if (i == 1) begin w_in_op = OP_SUB; w_in_a = 32'h8000_0000; w_in_b = 32'h1; end
      w_in_valid = 1'b1;
      #1;
      if (!w_in_ready) chk("w_ready", 32'd0, 32'd1);
      exp32.push_back(model(32, w_in_op, w_in_a, w_in_b, w_in_cin));
      @(negedge clk);
    end
    w_in_valid = 1'b0;
    tries = 0;
    while (exp32.size() > 0 && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    #4;
    chk("w_drain", 32'(exp32.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
